axi_master_arbiter: RTL and testbench

AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

---
 rtl/axi_master_arbiter.sv | 279 +++++++++++++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter
//   Two-requester AXI-lite arbiter funnelling M0/M1 onto one downstream
//   AXI-lite master (_S). Reads and writes are arbitrated by two independent
//   FSMs, so one read and one write can be outstanding at the same time.
//   Each side uses a round-robin pointer (rd_last / wr_last) that holds the
//   index of the requester served last.
//
// Ports
//   ACLK, ARESET               clock, synchronous active-high reset
//   *_M0 / *_M1                requester-side AR, R, AW, W, B channels
//   *_S                        shared downstream AR, R, AW, W, B channels
module axi_master_arbiter #(
  parameter int AXI_ADDR_BITS = 32,
  parameter int AXI_DATA_BITS = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  // requester 0
  input  logic [AXI_ADDR_BITS-1:0]   ARADDR_M0,
  input  logic                       ARVALID_M0,
  output logic                       ARREADY_M0,
  output logic [AXI_DATA_BITS-1:0]   RDATA_M0,
  output logic [1:0]                 RRESP_M0,
  output logic                       RVALID_M0,
  input  logic                       RREADY_M0,
  input  logic [AXI_ADDR_BITS-1:0]   AWADDR_M0,
  input  logic                       AWVALID_M0,
  output logic                       AWREADY_M0,
  input  logic [AXI_DATA_BITS-1:0]   WDATA_M0,
  input  logic [AXI_DATA_BITS/8-1:0] WSTRB_M0,
  input  logic                       WVALID_M0,
  output logic                       WREADY_M0,
  output logic [1:0]                 BRESP_M0,
  output logic                       BVALID_M0,
  input  logic                       BREADY_M0,
  // requester 1
  input  logic [AXI_ADDR_BITS-1:0]   ARADDR_M1,
  input  logic                       ARVALID_M1,
  output logic                       ARREADY_M1,
  output logic [AXI_DATA_BITS-1:0]   RDATA_M1,
  output logic [1:0]                 RRESP_M1,
  output logic                       RVALID_M1,
  input  logic                       RREADY_M1,
  input  logic [AXI_ADDR_BITS-1:0]   AWADDR_M1,
  input  logic                       AWVALID_M1,
  output logic                       AWREADY_M1,
  input  logic [AXI_DATA_BITS-1:0]   WDATA_M1,
  input  logic [AXI_DATA_BITS/8-1:0] WSTRB_M1,
  input  logic                       WVALID_M1,
  output logic                       WREADY_M1,
  output logic [1:0]                 BRESP_M1,
  output logic                       BVALID_M1,
  input  logic                       BREADY_M1,
  // shared downstream master
  output logic [AXI_ADDR_BITS-1:0]   ARADDR_S,
  output logic                       ARVALID_S,
  input  logic                       ARREADY_S,
  input  logic [AXI_DATA_BITS-1:0]   RDATA_S,
  input  logic [1:0]                 RRESP_S,
  input  logic                       RVALID_S,
  output logic                       RREADY_S,
  output logic [AXI_ADDR_BITS-1:0]   AWADDR_S,
  output logic                       AWVALID_S,
  input  logic                       AWREADY_S,
  output logic [AXI_DATA_BITS-1:0]   WDATA_S,
  output logic [AXI_DATA_BITS/8-1:0] WSTRB_S,
  output logic                       WVALID_S,
  input  logic                       WREADY_S,
  input  logic [1:0]                 BRESP_S,
  input  logic                       BVALID_S,
  output logic                       BREADY_S
);
  localparam int STRB_BITS = AXI_DATA_BITS / 8;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;

  // requester-side signals gathered into arrays indexed by requester
  logic [1:0]                          arvalid_m, rready_m, awvalid_m, wvalid_m, bready_m;
  logic [1:0][AXI_ADDR_BITS-1:0]       araddr_m, awaddr_m;
  logic [1:0][AXI_DATA_BITS-1:0]       wdata_m, rdata_m;
  logic [1:0][STRB_BITS-1:0]           wstrb_m;
  logic [1:0]                          arready_m, rvalid_m, awready_m, wready_m, bvalid_m;
  logic [1:0][1:0]                     rresp_m, bresp_m;

  assign arvalid_m = {ARVALID_M1, ARVALID_M0};
  assign rready_m  = {RREADY_M1, RREADY_M0};
  assign awvalid_m = {AWVALID_M1, AWVALID_M0};
  assign wvalid_m  = {WVALID_M1, WVALID_M0};
  assign bready_m  = {BREADY_M1, BREADY_M0};
  assign araddr_m  = {ARADDR_M1, ARADDR_M0};
  assign awaddr_m  = {AWADDR_M1, AWADDR_M0};
  assign wdata_m   = {WDATA_M1, WDATA_M0};
  assign wstrb_m   = {WSTRB_M1, WSTRB_M0};

  // ---------------- read side ----------------
  rd_state_t                rd_state_reg, rd_state_next;
  logic                     rd_last_reg, rd_last_next;
  logic                     rd_grant_reg, rd_grant_next;
  logic                     arvalid_reg, arvalid_next;
  logic [AXI_ADDR_BITS-1:0] araddr_reg, araddr_next;
  logic                     rd_sel, rd_accept, rd_in_data;

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_last_next  = rd_last_reg;
    rd_grant_next = rd_grant_reg;
    arvalid_next  = arvalid_reg;
    araddr_next   = araddr_reg;
    rd_accept     = 1'b0;
    // on contention serve the requester that was not served last
    rd_sel = (&arvalid_m) ? ~rd_last_reg : arvalid_m[1];
    case (rd_state_reg)
      R_IDLE: begin
        if (|arvalid_m) begin
          rd_accept     = 1'b1;
          rd_grant_next = rd_sel;
          araddr_next   = araddr_m[rd_sel];
          arvalid_next  = 1'b1;
          rd_state_next = R_ADDR;
        end
      end
      R_ADDR: begin
        if (ARREADY_S) begin
          arvalid_next  = 1'b0;
          rd_state_next = R_DATA;
        end
      end
      R_DATA: begin
        if (RVALID_S && rready_m[rd_grant_reg]) begin
          rd_last_next  = rd_grant_reg;
          rd_state_next = R_IDLE;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_reg <= R_IDLE;
      rd_last_reg  <= 1'b1;
      rd_grant_reg <= 1'b0;
      arvalid_reg  <= 1'b0;
      araddr_reg   <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_last_reg  <= rd_last_next;
      rd_grant_reg <= rd_grant_next;
      arvalid_reg  <= arvalid_next;
      araddr_reg   <= araddr_next;
    end
  end

  // requester-facing outputs are forced low while reset is held
  assign rd_in_data = (rd_state_reg == R_DATA) && !ARESET;
  assign ARVALID_S  = arvalid_reg;
  assign ARADDR_S   = araddr_reg;
  assign RREADY_S   = rd_in_data && rready_m[rd_grant_reg];

  // ---------------- write side ----------------
  wr_state_t                wr_state_reg, wr_state_next;
  logic                     wr_last_reg, wr_last_next;
  logic                     wr_grant_reg, wr_grant_next;
  logic                     awvalid_reg, awvalid_next;
  logic                     wvalid_reg, wvalid_next;
  logic [AXI_ADDR_BITS-1:0] awaddr_reg, awaddr_next;
  logic [AXI_DATA_BITS-1:0] wdata_reg, wdata_next;
  logic [STRB_BITS-1:0]     wstrb_reg, wstrb_next;
  logic [1:0]               wr_elig;
  logic                     wr_sel, wr_accept, wr_in_resp;

  // a write is only taken when address and data arrive together
  assign wr_elig = awvalid_m & wvalid_m;

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_last_next  = wr_last_reg;
    wr_grant_next = wr_grant_reg;
    awvalid_next  = awvalid_reg;
    wvalid_next   = wvalid_reg;
    awaddr_next   = awaddr_reg;
    wdata_next    = wdata_reg;
    wstrb_next    = wstrb_reg;
    wr_accept     = 1'b0;
    wr_sel = (&wr_elig) ? ~wr_last_reg : wr_elig[1];
    case (wr_state_reg)
      W_IDLE: begin
        if (|wr_elig) begin
          wr_accept     = 1'b1;
          wr_grant_next = wr_sel;
          awaddr_next   = awaddr_m[wr_sel];
          wdata_next    = wdata_m[wr_sel];
          wstrb_next    = wstrb_m[wr_sel];
          awvalid_next  = 1'b1;
          wvalid_next   = 1'b1;
          wr_state_next = W_ADDR;
        end
      end
      W_ADDR: begin
        // AW and W complete independently; leave once both are done
        if (awvalid_reg && AWREADY_S) awvalid_next = 1'b0;
        if (wvalid_reg && WREADY_S)   wvalid_next  = 1'b0;
        if ((!awvalid_reg || AWREADY_S) && (!wvalid_reg || WREADY_S))
          wr_state_next = W_RESP;
      end
      W_RESP: begin
        if (BVALID_S && bready_m[wr_grant_reg]) begin
          wr_last_next  = wr_grant_reg;
          wr_state_next = W_IDLE;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_reg <= W_IDLE;
      wr_last_reg  <= 1'b1;
      wr_grant_reg <= 1'b0;
      awvalid_reg  <= 1'b0;
      wvalid_reg   <= 1'b0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_last_reg  <= wr_last_next;
      wr_grant_reg <= wr_grant_next;
      awvalid_reg  <= awvalid_next;
      wvalid_reg   <= wvalid_next;
      awaddr_reg   <= awaddr_next;
      wdata_reg    <= wdata_next;
      wstrb_reg    <= wstrb_next;
    end
  end

  assign wr_in_resp = (wr_state_reg == W_RESP) && !ARESET;
  assign AWVALID_S  = awvalid_reg;
  assign AWADDR_S   = awaddr_reg;
  assign WVALID_S   = wvalid_reg;
  assign WDATA_S    = wdata_reg;
  assign WSTRB_S    = wstrb_reg;
  assign BREADY_S   = wr_in_resp && bready_m[wr_grant_reg];

  // ---------------- per-requester routing ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic rd_mine, wr_mine;
    assign rd_mine       = rd_in_data && (rd_grant_reg == 1'(gi));
    assign wr_mine       = wr_in_resp && (wr_grant_reg == 1'(gi));
    assign arready_m[gi] = !ARESET && rd_accept && (rd_sel == 1'(gi));
    assign awready_m[gi] = !ARESET && wr_accept && (wr_sel == 1'(gi));
    assign wready_m[gi]  = awready_m[gi];
    assign rvalid_m[gi]  = rd_mine && RVALID_S;
    assign rdata_m[gi]   = rd_mine ? RDATA_S : '0;
    assign rresp_m[gi]   = rd_mine ? RRESP_S : 2'b00;
    assign bvalid_m[gi]  = wr_mine && BVALID_S;
    assign bresp_m[gi]   = wr_mine ? BRESP_S : 2'b00;
  end

  assign ARREADY_M0 = arready_m[0];
  assign ARREADY_M1 = arready_m[1];
  assign RVALID_M0  = rvalid_m[0];
  assign RVALID_M1  = rvalid_m[1];
  assign RDATA_M0   = rdata_m[0];
  assign RDATA_M1   = rdata_m[1];
  assign RRESP_M0   = rresp_m[0];
  assign RRESP_M1   = rresp_m[1];
  assign AWREADY_M0 = awready_m[0];
  assign AWREADY_M1 = awready_m[1];
  assign WREADY_M0  = wready_m[0];
  assign WREADY_M1  = wready_m[1];
  assign BVALID_M0  = bvalid_m[0];
  assign BVALID_M1  = bvalid_m[1];
  assign BRESP_M0   = bresp_m[0];
  assign BRESP_M1   = bresp_m[1];

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Testbench for axi_master_arbiter: table of read transactions exercising
// round-robin arbitration, plus hand sequences for concurrent read/write,
// split AW/W handshakes, R backpressure and reset in the middle of a read.
module tb_axi_master_arbiter;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] ARADDR_M0, ARADDR_M1, AWADDR_M0, AWADDR_M1, WDATA_M0, WDATA_M1;
  logic [3:0]  WSTRB_M0, WSTRB_M1;
  logic        ARVALID_M0, ARVALID_M1, RREADY_M0, RREADY_M1;
  logic        AWVALID_M0, AWVALID_M1, WVALID_M0, WVALID_M1, BREADY_M0, BREADY_M1;
  logic        ARREADY_M0, ARREADY_M1, RVALID_M0, RVALID_M1;
  logic        AWREADY_M0, AWREADY_M1, WREADY_M0, WREADY_M1, BVALID_M0, BVALID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1, BRESP_M0, BRESP_M1;
  logic [31:0] ARADDR_S, AWADDR_S, WDATA_S, RDATA_S;
  logic [3:0]  WSTRB_S;
  logic        ARVALID_S, ARREADY_S, RVALID_S, RREADY_S;
  logic        AWVALID_S, AWREADY_S, WVALID_S, WREADY_S, BVALID_S, BREADY_S;
  logic [1:0]  RRESP_S, BRESP_S;

  axi_master_arbiter #(.AXI_ADDR_BITS(32), .AXI_DATA_BITS(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARADDR_M0(ARADDR_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .AWADDR_M0(AWADDR_M0), .AWVALID_M0(AWVALID_M0), .AWREADY_M0(AWREADY_M0),
    .WDATA_M0(WDATA_M0), .WSTRB_M0(WSTRB_M0), .WVALID_M0(WVALID_M0), .WREADY_M0(WREADY_M0),
    .BRESP_M0(BRESP_M0), .BVALID_M0(BVALID_M0), .BREADY_M0(BREADY_M0),
    .ARADDR_M1(ARADDR_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .AWADDR_M1(AWADDR_M1), .AWVALID_M1(AWVALID_M1), .AWREADY_M1(AWREADY_M1),
    .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WVALID_M1(WVALID_M1), .WREADY_M1(WREADY_M1),
    .BRESP_M1(BRESP_M1), .BVALID_M1(BVALID_M1), .BREADY_M1(BREADY_M1),
    .ARADDR_S(ARADDR_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .AWADDR_S(AWADDR_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
    .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        rv0;
    logic        rv1;
    logic        grant;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_vec_t;

  typedef struct {
    logic        grant;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  typedef struct {
    logic        grant;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Full read through the arbiter; grant comes from the vector table.
  task automatic do_read(input rd_vec_t v);
    rd_exp_t e;
    @(negedge ACLK);
    ARVALID_M0 = v.rv0; ARADDR_M0 = v.addr;
    ARVALID_M1 = v.rv1; ARADDR_M1 = v.addr | 32'h8000_0000;
    e.grant = v.grant;
    e.addr  = v.grant ? (v.addr | 32'h8000_0000) : v.addr;
    e.data  = v.data;
    e.resp  = v.resp;
    rd_q.push_back(e);
    #1;
    chk("arready_m0", ARREADY_M0, !v.grant);
    chk("arready_m1", ARREADY_M1, v.grant);
    chk("arvalid_s_not_yet", ARVALID_S, 0);
    @(negedge ACLK);
    ARVALID_M0 = 0; ARVALID_M1 = 0;
    #1;
    chk("arvalid_s", ARVALID_S, 1);
    chk("araddr_s", ARADDR_S, rd_q[0].addr);
    ARREADY_S = 1;
    @(negedge ACLK);
    ARREADY_S = 0;
    RVALID_S = 1; RDATA_S = v.data; RRESP_S = v.resp;
    RREADY_M0 = 1; RREADY_M1 = 1;
    #1;
    chk("arvalid_s_clear", ARVALID_S, 0);
    e = rd_q.pop_front();
    if (e.grant) begin
      chk("rvalid_m1", RVALID_M1, 1); chk("rdata_m1", RDATA_M1, e.data);
      chk("rresp_m1", RRESP_M1, e.resp);
      chk("rvalid_m0_other", RVALID_M0, 0); chk("rdata_m0_other", RDATA_M0, 0);
    end else begin
      chk("rvalid_m0", RVALID_M0, 1); chk("rdata_m0", RDATA_M0, e.data);
      chk("rresp_m0", RRESP_M0, e.resp);
      chk("rvalid_m1_other", RVALID_M1, 0); chk("rdata_m1_other", RDATA_M1, 0);
    end
    @(negedge ACLK);
    RVALID_S = 0; RREADY_M0 = 0; RREADY_M1 = 0;
  endtask

  // Write with AW and W accepted downstream in the same cycle.
  task automatic do_write(input logic v0, input logic v1, input logic g,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] bresp);
    wr_exp_t e;
    @(negedge ACLK);
    AWVALID_M0 = v0; WVALID_M0 = v0; AWADDR_M0 = addr; WDATA_M0 = data; WSTRB_M0 = strb;
    AWVALID_M1 = v1; WVALID_M1 = v1; AWADDR_M1 = addr | 32'h1; WDATA_M1 = ~data; WSTRB_M1 = ~strb;
    e.grant = g;
    e.addr  = g ? (addr | 32'h1) : addr;
    e.data  = g ? ~data : data;
    e.strb  = g ? ~strb : strb;
    e.bresp = bresp;
    wr_q.push_back(e);
    #1;
    chk("awready_m0", AWREADY_M0, !g);
    chk("wready_m1", WREADY_M1, g);
    @(negedge ACLK);
    AWVALID_M0 = 0; WVALID_M0 = 0; AWVALID_M1 = 0; WVALID_M1 = 0;
    #1;
    chk("awvalid_s", AWVALID_S, 1); chk("wvalid_s", WVALID_S, 1);
    chk("awaddr_s", AWADDR_S, wr_q[0].addr); chk("wdata_s", WDATA_S, wr_q[0].data);
    chk("wstrb_s", WSTRB_S, wr_q[0].strb);
    AWREADY_S = 1; WREADY_S = 1;
    @(negedge ACLK);
    AWREADY_S = 0; WREADY_S = 0;
    BVALID_S = 1; BRESP_S = bresp; BREADY_M0 = 1; BREADY_M1 = 1;
    #1;
    e = wr_q.pop_front();
    chk("bvalid_granted", e.grant ? BVALID_M1 : BVALID_M0, 1);
    chk("bvalid_other", e.grant ? BVALID_M0 : BVALID_M1, 0);
    chk("bresp_granted", e.grant ? BRESP_M1 : BRESP_M0, e.bresp);
    @(negedge ACLK);
    BVALID_S = 0; BRESP_S = 0; BREADY_M0 = 0; BREADY_M1 = 0;
  endtask

  rd_vec_t tbl [8];
  rd_exp_t re;
  wr_exp_t we;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // grants follow rd_last, which starts at 1 so M0 wins first contention
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h1111_1111, 2'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h2222_2222, 2'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0208, 32'h3333_3333, 2'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_020C, 32'h4444_4444, 2'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0210, 32'h5555_5555, 2'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0214, 32'h6666_6666, 2'd2};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_0218, 32'h7777_7777, 2'd3};

    ARESET = 1;
    ARADDR_M0 = 0; ARADDR_M1 = 0; AWADDR_M0 = 0; AWADDR_M1 = 0;
    WDATA_M0 = 0; WDATA_M1 = 0; WSTRB_M0 = 0; WSTRB_M1 = 0;
    ARVALID_M0 = 1; ARVALID_M1 = 0; RREADY_M0 = 0; RREADY_M1 = 0;
    AWVALID_M0 = 0; AWVALID_M1 = 1; WVALID_M0 = 0; WVALID_M1 = 1;
    BREADY_M0 = 0; BREADY_M1 = 0;
    ARREADY_S = 0; RDATA_S = 0; RRESP_S = 0; RVALID_S = 0;
    AWREADY_S = 0; WREADY_S = 0; BRESP_S = 0; BVALID_S = 0;

    // reset state with requests pending
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    #1;
    chk("rst_arready_m0", ARREADY_M0, 0);
    chk("rst_awready_m1", AWREADY_M1, 0);
    chk("rst_wready_m1", WREADY_M1, 0);
    chk("rst_arvalid_s", ARVALID_S, 0);
    chk("rst_araddr_s", ARADDR_S, 0);
    chk("rst_awvalid_s", AWVALID_S, 0);
    chk("rst_wvalid_s", WVALID_S, 0);
    chk("rst_wdata_s", WDATA_S, 0);
    chk("rst_wstrb_s", WSTRB_S, 0);

    // grant is offered in the very first cycle out of reset
    @(negedge ACLK);
    ARESET = 0;
    #1;
    chk("first_arready_m0", ARREADY_M0, 1);
    chk("first_awready_m1", AWREADY_M1, 1);
    #1;
    ARVALID_M0 = 0; AWVALID_M1 = 0; WVALID_M1 = 0;

    // table-driven read arbitration
    for (int i = 0; i < 8; i++) begin
      do_read(tbl[i]);
      $display("read vector %0d done: grant M%0d", i, tbl[i].grant);
    end

    // concurrent read (M0) and write (M1)
    @(negedge ACLK);
    ARVALID_M0 = 1; ARADDR_M0 = 32'h0;
    AWVALID_M1 = 1; WVALID_M1 = 1; AWADDR_M1 = 32'h2000; WDATA_M1 = 32'h1234_5678; WSTRB_M1 = 4'hF;
    rd_q.push_back('{1'b0, 32'h0, 32'h55AA_55AA, 2'd0});
    wr_q.push_back('{1'b1, 32'h2000, 32'h1234_5678, 4'hF, 2'd0});
    #1;
    chk("cc_arready_m0", ARREADY_M0, 1);
    chk("cc_awready_m1", AWREADY_M1, 1);
    chk("cc_wready_m1", WREADY_M1, 1);
    chk("cc_awready_m0", AWREADY_M0, 0);
    @(negedge ACLK);
    ARVALID_M0 = 0; AWVALID_M1 = 0; WVALID_M1 = 0;
    #1;
    chk("cc_arvalid_s", ARVALID_S, 1);
    chk("cc_araddr_s", ARADDR_S, rd_q[0].addr);
    chk("cc_awvalid_s", AWVALID_S, 1);
    chk("cc_wvalid_s", WVALID_S, 1);
    chk("cc_awaddr_s", AWADDR_S, wr_q[0].addr);
    chk("cc_wdata_s", WDATA_S, wr_q[0].data);
    chk("cc_wstrb_s", WSTRB_S, wr_q[0].strb);
    ARREADY_S = 1; AWREADY_S = 1; WREADY_S = 1;
    @(negedge ACLK);
    ARREADY_S = 0; AWREADY_S = 0; WREADY_S = 0;
    RVALID_S = 1; RDATA_S = 32'h55AA_55AA; RRESP_S = 0; RREADY_M0 = 1;
    BVALID_S = 1; BRESP_S = 0; BREADY_M1 = 1;
    #1;
    re = rd_q.pop_front();
    we = wr_q.pop_front();
    chk("cc_rvalid_m0", RVALID_M0, 1);
    chk("cc_rdata_m0", RDATA_M0, re.data);
    chk("cc_rvalid_m1", RVALID_M1, 0);
    chk("cc_bvalid_m1", BVALID_M1, 1);
    chk("cc_bresp_m1", BRESP_M1, we.bresp);
    chk("cc_bvalid_m0", BVALID_M0, 0);
    @(negedge ACLK);
    RVALID_S = 0; RREADY_M0 = 0; BVALID_S = 0; BREADY_M1 = 0;
    $display("concurrent read/write done");

    // split write: AW accepted two cycles before W, SLVERR response
    @(negedge ACLK);
    AWVALID_M1 = 1; WVALID_M1 = 1; AWADDR_M1 = 32'h3000; WDATA_M1 = 32'hA5A5_5A5A; WSTRB_M1 = 4'h3;
    wr_q.push_back('{1'b1, 32'h3000, 32'hA5A5_5A5A, 4'h3, 2'd2});
    #1;
    chk("sp_awready_m1", AWREADY_M1, 1);
    chk("sp_wready_m1", WREADY_M1, 1);
    @(negedge ACLK);
    AWVALID_M1 = 0; WVALID_M1 = 0;
    AWREADY_S = 1;
    #1;
    chk("sp_awvalid_s", AWVALID_S, 1);
    chk("sp_wdata_s", WDATA_S, wr_q[0].data);
    @(negedge ACLK);
    AWREADY_S = 0;
    BVALID_S = 1; BRESP_S = 2'd2; BREADY_M1 = 1;
    #1;
    chk("sp_awvalid_s_clear", AWVALID_S, 0);
    chk("sp_wvalid_s_held", WVALID_S, 1);
    chk("sp_bvalid_early", BVALID_M1, 0);
    chk("sp_bready_early", BREADY_S, 0);
    @(negedge ACLK);
    WREADY_S = 1;
    #1;
    chk("sp_bvalid_early2", BVALID_M1, 0);
    @(negedge ACLK);
    WREADY_S = 0;
    #1;
    we = wr_q.pop_front();
    chk("sp_wvalid_s_clear", WVALID_S, 0);
    chk("sp_bvalid_m1", BVALID_M1, 1);
    chk("sp_bresp_m1", BRESP_M1, we.bresp);
    chk("sp_bready_s", BREADY_S, 1);
    @(negedge ACLK);
    BVALID_S = 0; BRESP_S = 0; BREADY_M1 = 0;
    $display("split write done");

    // R backpressure from M1 for three cycles
    @(negedge ACLK);
    ARVALID_M1 = 1; ARADDR_M1 = 32'h400;
    rd_q.push_back('{1'b1, 32'h400, 32'hCAFE_F00D, 2'd0});
    #1;
    chk("bp_arready_m1", ARREADY_M1, 1);
    @(negedge ACLK);
    ARVALID_M1 = 0; ARREADY_S = 1;
    @(negedge ACLK);
    ARREADY_S = 0; RVALID_S = 1; RDATA_S = 32'hCAFE_F00D; RRESP_S = 0; RREADY_M1 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rready_s_low", RREADY_S, 0);
      chk("bp_rvalid_m1", RVALID_M1, 1);
      @(negedge ACLK);
    end
    RREADY_M1 = 1;
    #1;
    re = rd_q.pop_front();
    chk("bp_rready_s_high", RREADY_S, 1);
    chk("bp_rdata_m1", RDATA_M1, re.data);
    @(negedge ACLK);
    #1;
    chk("bp_done_rvalid_m1", RVALID_M1, 0);
    chk("bp_done_rready_s", RREADY_S, 0);
    RVALID_S = 0; RREADY_M1 = 0;
    $display("backpressure read done");

    // reset while in R_DATA abandons the read
    @(negedge ACLK);
    ARVALID_M0 = 1; ARADDR_M0 = 32'h300;
    @(negedge ACLK);
    ARVALID_M0 = 0; ARREADY_S = 1;
    @(negedge ACLK);
    ARREADY_S = 0; RVALID_S = 1; RDATA_S = 32'hBAD0_BAD0; RREADY_M0 = 0;
    #1;
    chk("mr_rvalid_m0_before", RVALID_M0, 1);
    @(negedge ACLK);
    ARESET = 1;
    #1;
    chk("mr_rvalid_m0_in_rst", RVALID_M0, 0);
    @(negedge ACLK);
    ARESET = 0;
    #1;
    chk("mr_rvalid_m0_after", RVALID_M0, 0);
    chk("mr_rready_s_after", RREADY_S, 0);
    RVALID_S = 0; RDATA_S = 0;
    do_read('{1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0BAD_CAFE, 2'd0});
    $display("reset mid-read recovered");

    // write contention: wr_last starts at 1, so M0 then M1
    do_write(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'hFACE_0001, 4'h5, 2'd0);
    $display("write contention 1 done");
    do_write(1'b1, 1'b1, 1'b1, 32'h0000_5000, 32'hFACE_0002, 4'h9, 2'd3);
    $display("write contention 2 done");

    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
